mips_pc_sequencer: RTL and testbench

//  Program-counter sequencer for the Harvard MIPS core. Owns instr_address and
//  the branch-delay-slot state machine. Applies J/JR/branch redirects after

---
 rtl/mips_pc_pkg.sv | 24 ++
 rtl/mips_redirect_select.sv | 32 +++
 rtl/mips_pc_sequencer.sv | 106 ++++++++++
 tb/tb_mips_pc_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pc_pkg.sv
// Shared types and target-address helpers for the MIPS program-counter sequencer.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm16);
        return pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // The region bits come from the delay-slot address, not from the jump itself.
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx26);
        logic [31:0] region;
        region = (pc + 32'd4) & 32'hF000_0000;
        return region | {4'b0000, idx26, 2'b00};
    endfunction

endpackage

// File: rtl/mips_redirect_select.sv
// Combinational redirect decode: priority jr > jump > taken branch, plus target calculation.
module mips_redirect_select
    import mips_pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_valid,
    input  logic [25:0] jump_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = 32'h0000_0000;
        if (jr_valid) begin
            redirect = 1'b1;
            target   = jr_target;
        end else if (jump_valid) begin
            redirect = 1'b1;
            target   = jump_target(pc, jump_index);
        end else if (branch_valid && branch_taken) begin
            redirect = 1'b1;
            target   = branch_target(pc, branch_offset);
        end
    end

endmodule

// File: rtl/mips_pc_sequencer.sv
// Program counter, pending-redirect register and branch-delay-slot FSM for the Harvard MIPS core.
module mips_pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_valid,
    input  logic [25:0] jump_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] instr_address,
    output logic [31:0] link_address,
    output logic        in_delay_slot,
    output logic        active,
    output logic        address_error
);

    pc_state_t   state, next_state;
    logic [31:0] pc, next_pc;
    logic [31:0] pending, next_pending;
    logic        error_flag, next_error_flag;
    logic        redirect;
    logic [31:0] target;
    logic        advance;

    mips_redirect_select u_redirect_select (
        .pc            (pc),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_index    (jump_index),
        .jr_valid      (jr_valid),
        .jr_target     (jr_target),
        .redirect      (redirect),
        .target        (target)
    );

    assign advance = clk_enable && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_VECTOR;
            pending    <= 32'h0000_0000;
            error_flag <= 1'b0;
        end else begin
            state      <= next_state;
            pc         <= next_pc;
            pending    <= next_pending;
            error_flag <= next_error_flag;
        end
    end

    // Redirect requests are only honoured in RUN; the delay slot always falls through to pending.
    always_comb begin
        next_state      = state;
        next_pc         = pc;
        next_pending    = pending;
        next_error_flag = error_flag;
        if (advance) begin
            case (state)
                RUN: begin
                    next_pc = pc + 32'd4;
                    if (redirect) begin
                        next_pending = target;
                        next_state   = DELAY;
                    end
                end
                DELAY: begin
                    next_pc = pending;
                    if (pending == HALT_ADDR) begin
                        next_state = HALTED;
                    end else if (pending[1:0] != 2'b00) begin
                        next_state      = HALTED;
                        next_error_flag = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
                HALTED: begin
                    next_state = HALTED;
                end
                default: begin
                    next_state = HALTED;
                end
            endcase
        end
    end

    assign instr_address = pc;
    assign link_address  = pc + 32'd8;
    assign in_delay_slot = (state == DELAY);
    assign active        = (state != HALTED);
    assign address_error = error_flag;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed self-checking bench for mips_pc_sequencer: delay slots, halt, stall, reset and alignment.
module tb_mips_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump_valid;
    logic [25:0] jump_index;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] instr_address;
    logic [31:0] link_address;
    logic        in_delay_slot;
    logic        active;
    logic        address_error;

    int checks   = 0;
    int failures = 0;

    mips_pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_index    (jump_index),
        .jr_valid      (jr_valid),
        .jr_target     (jr_target),
        .instr_address (instr_address),
        .link_address  (link_address),
        .in_delay_slot (in_delay_slot),
        .active        (active),
        .address_error (address_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clk_enable    = 1'b1;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0000;
        jump_valid    = 1'b0;
        jump_index    = 26'h0;
        jr_valid      = 1'b0;
        jr_target     = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue_jump_to_bfc00010();
        jump_valid = 1'b1;
        jump_index = 26'h3F00004;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (instr_address !== 32'hBFC00000) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", instr_address, 32'hBFC00000); end
        checks++; if (link_address !== 32'hBFC00008) begin failures++; $display("[TB] FAIL reset_link: got %h expected %h", link_address, 32'hBFC00008); end
        checks++; if (active !== 1'b1) begin failures++; $display("[TB] FAIL reset_active: got %b expected 1", active); end
        checks++; if (in_delay_slot !== 1'b0) begin failures++; $display("[TB] FAIL reset_dslot: got %b expected 0", in_delay_slot); end
        checks++; if (address_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", address_error); end
    endtask

    task automatic test_jump();
        issue_jump_to_bfc00010();
        checks++; if (instr_address !== 32'hBFC00004) begin failures++; $display("[TB] FAIL jump_slot_pc: got %h expected %h", instr_address, 32'hBFC00004); end
        checks++; if (in_delay_slot !== 1'b1) begin failures++; $display("[TB] FAIL jump_slot_flag: got %b expected 1", in_delay_slot); end
        checks++; if (link_address !== 32'hBFC0000C) begin failures++; $display("[TB] FAIL jump_slot_link: got %h expected %h", link_address, 32'hBFC0000C); end
        step();
        checks++; if (instr_address !== 32'hBFC00010) begin failures++; $display("[TB] FAIL jump_target_pc: got %h expected %h", instr_address, 32'hBFC00010); end
        checks++; if (in_delay_slot !== 1'b0) begin failures++; $display("[TB] FAIL jump_target_flag: got %b expected 0", in_delay_slot); end
    endtask

    task automatic test_branch_taken();
        branch_valid  = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFD;
        step();
        clear_inputs();
        checks++; if (instr_address !== 32'hBFC00014) begin failures++; $display("[TB] FAIL br_slot_pc: got %h expected %h", instr_address, 32'hBFC00014); end
        checks++; if (in_delay_slot !== 1'b1) begin failures++; $display("[TB] FAIL br_slot_flag: got %b expected 1", in_delay_slot); end
        step();
        checks++; if (instr_address !== 32'hBFC00008) begin failures++; $display("[TB] FAIL br_target_pc: got %h expected %h", instr_address, 32'hBFC00008); end
    endtask

    task automatic test_jr_halt();
        jr_valid  = 1'b1;
        jr_target = 32'h0000_0000;
        step();
        clear_inputs();
        checks++; if (instr_address !== 32'hBFC0000C) begin failures++; $display("[TB] FAIL jr_slot_pc: got %h expected %h", instr_address, 32'hBFC0000C); end
        checks++; if (active !== 1'b1) begin failures++; $display("[TB] FAIL jr_slot_active: got %b expected 1", active); end
        step();
        checks++; if (instr_address !== 32'h00000000) begin failures++; $display("[TB] FAIL halt_pc: got %h expected %h", instr_address, 32'h0); end
        checks++; if (active !== 1'b0) begin failures++; $display("[TB] FAIL halt_active: got %b expected 0", active); end
        checks++; if (address_error !== 1'b0) begin failures++; $display("[TB] FAIL halt_err: got %b expected 0", address_error); end
        for (int i = 0; i < 10; i++) begin
            clk_enable    = 1'b1;
            stall         = 1'(i % 3 == 2);
            jr_valid      = 1'(i % 2);
            jr_target     = $urandom;
            jump_valid    = 1'(i % 2 == 0);
            jump_index    = 26'($urandom);
            branch_valid  = 1'b1;
            branch_taken  = 1'b1;
            branch_offset = 16'($urandom);
            step();
            checks++; if (instr_address !== 32'h0 || active !== 1'b0 || in_delay_slot !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_hold[%0d]: got pc=%h active=%b dslot=%b expected pc=00000000 active=0 dslot=0", i, instr_address, active, in_delay_slot);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_delay();
        do_reset();
        issue_jump_to_bfc00010();
        checks++; if (in_delay_slot !== 1'b1) begin failures++; $display("[TB] FAIL rst_delay_pre: got %b expected 1", in_delay_slot); end
        #2 reset = 1'b1;
        #1;
        checks++; if (instr_address !== 32'hBFC00000) begin failures++; $display("[TB] FAIL rst_async_pc: got %h expected %h", instr_address, 32'hBFC00000); end
        checks++; if (active !== 1'b1 || in_delay_slot !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_flags: got active=%b dslot=%b expected active=1 dslot=0", active, in_delay_slot); end
        #1 reset = 1'b0;
        step();
        checks++; if (instr_address !== 32'hBFC00004) begin failures++; $display("[TB] FAIL rst_discard_pc1: got %h expected %h", instr_address, 32'hBFC00004); end
        step();
        checks++; if (instr_address !== 32'hBFC00008) begin failures++; $display("[TB] FAIL rst_discard_pc2: got %h expected %h", instr_address, 32'hBFC00008); end
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        issue_jump_to_bfc00010();
        step();
        branch_valid  = 1'b1;
        branch_taken  = 1'b0;
        branch_offset = 16'hFFFD;
        step();
        clear_inputs();
        checks++; if (instr_address !== 32'hBFC00014 || in_delay_slot !== 1'b0) begin failures++; $display("[TB] FAIL nt_pc1: got pc=%h dslot=%b expected pc=BFC00014 dslot=0", instr_address, in_delay_slot); end
        step();
        checks++; if (instr_address !== 32'hBFC00018 || in_delay_slot !== 1'b0) begin failures++; $display("[TB] FAIL nt_pc2: got pc=%h dslot=%b expected pc=BFC00018 dslot=0", instr_address, in_delay_slot); end
    endtask

    task automatic test_stall();
        do_reset();
        issue_jump_to_bfc00010();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                stall      = 1'b0;
                clk_enable = 1'b0;
            end
            step();
            checks++; if (instr_address !== 32'hBFC00004 || link_address !== 32'hBFC0000C || in_delay_slot !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d]: got pc=%h link=%h dslot=%b expected pc=BFC00004 link=BFC0000C dslot=1", i, instr_address, link_address, in_delay_slot);
            end
        end
        clear_inputs();
        step();
        checks++; if (instr_address !== 32'hBFC00010 || link_address !== 32'hBFC00018) begin failures++; $display("[TB] FAIL stall_land: got pc=%h link=%h expected pc=BFC00010 link=BFC00018", instr_address, link_address); end
    endtask

    task automatic test_misaligned();
        do_reset();
        jr_valid  = 1'b1;
        jr_target = 32'hBFC00006;
        step();
        clear_inputs();
        checks++; if (in_delay_slot !== 1'b1 || address_error !== 1'b0) begin failures++; $display("[TB] FAIL mis_slot: got dslot=%b err=%b expected dslot=1 err=0", in_delay_slot, address_error); end
        step();
        checks++; if (instr_address !== 32'hBFC00006) begin failures++; $display("[TB] FAIL mis_pc: got %h expected %h", instr_address, 32'hBFC00006); end
        checks++; if (address_error !== 1'b1 || active !== 1'b0) begin failures++; $display("[TB] FAIL mis_flags: got err=%b active=%b expected err=1 active=0", address_error, active); end
        step();
        step();
        checks++; if (instr_address !== 32'hBFC00006 || address_error !== 1'b1) begin failures++; $display("[TB] FAIL mis_hold: got pc=%h err=%b expected pc=BFC00006 err=1", instr_address, address_error); end
    endtask

    task automatic test_wrap();
        do_reset();
        jr_valid  = 1'b1;
        jr_target = 32'hFFFFFFFC;
        step();
        clear_inputs();
        step();
        checks++; if (instr_address !== 32'hFFFFFFFC || link_address !== 32'h00000004) begin failures++; $display("[TB] FAIL wrap_pre: got pc=%h link=%h expected pc=FFFFFFFC link=00000004", instr_address, link_address); end
        step();
        checks++; if (instr_address !== 32'h00000000 || active !== 1'b1) begin failures++; $display("[TB] FAIL wrap_pc: got pc=%h active=%b expected pc=00000000 active=1", instr_address, active); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #12;
        test_reset();
        test_jump();
        test_branch_taken();
        test_jr_halt();
        test_reset_in_delay();
        test_branch_not_taken();
        test_stall();
        test_misaligned();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
